// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: evaluates predicted conditional branches, raises flush/redirect on a
// mispredict and queues predictor update records. Define BRU_STATS_EN to add branch/mispredict counters.
module branch_resolve_unit #(
    parameter int HIST_W = 10,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_inst,
    input  logic [31:0]       in_rs1_data,
    input  logic [31:0]       in_rs2_data,
    input  logic              in_pdt_res,
    input  logic              in_which_pdt,
    input  logic [HIST_W-1:0] in_history,
    output logic              flush,
    output logic [31:0]       redirect_pc,
    output logic              upd_valid,
    input  logic              upd_ready,
    output logic [31:0]       upd_pc,
    output logic [HIST_W-1:0] upd_history,
    output logic              upd_branch_res,
    output logic              upd_pdt_true,
    output logic              upd_which_pdt
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(QDEPTH);

    typedef struct packed {
        logic [31:0]       pc;
        logic [HIST_W-1:0] hist;
        logic              res;
        logic              ok;
        logic              which;
    } rec_t;

    logic        is_branch;
    logic        accept;
    logic        resolve;
    logic        taken;
    logic        mispredict;
    logic [31:0] imm_b;
    logic [31:0] target;
    logic [31:0] fall_thru;

    rec_t          mem [QDEPTH];
    rec_t          last_q;
    rec_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign in_ready  = (count != FULL_CNT);
    assign is_branch = (in_inst[6:0] == 7'b1100011);
    assign accept    = in_valid && in_ready;
    // A branch accepted while flush is high is on the wrong path and leaves no trace.
    assign resolve   = accept && is_branch && !flush;

    assign imm_b     = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign target    = in_pc + imm_b;
    assign fall_thru = in_pc + 32'd4;

    always_comb begin
        taken = 1'b0;
        case (in_inst[14:12])
            3'b000:  taken = (in_rs1_data == in_rs2_data);
            3'b001:  taken = (in_rs1_data != in_rs2_data);
            3'b100:  taken = ($signed(in_rs1_data) <  $signed(in_rs2_data));
            3'b101:  taken = ($signed(in_rs1_data) >= $signed(in_rs2_data));
            3'b110:  taken = (in_rs1_data <  in_rs2_data);
            3'b111:  taken = (in_rs1_data >= in_rs2_data);
            default: taken = 1'b0;
        endcase
    end

    assign mispredict = (taken != in_pdt_res);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush       <= 1'b0;
            redirect_pc <= 32'd0;
        end else begin
            flush <= resolve && mispredict;
            if (resolve && mispredict) begin
                redirect_pc <= taken ? target : fall_thru;
            end
        end
    end

    assign push = resolve;
    assign pop  = upd_valid && upd_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{pc: in_pc, hist: in_history, res: taken,
                                 ok: !mispredict, which: in_which_pdt};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                last_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // When empty the ports keep showing the most recently drained record.
    assign upd_valid      = (count != '0);
    assign head           = upd_valid ? mem[rd_ptr] : last_q;
    assign upd_pc         = head.pc;
    assign upd_history    = head.hist;
    assign upd_branch_res = head.res;
    assign upd_pdt_true   = head.ok;
    assign upd_which_pdt  = head.which;

`ifdef BRU_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else if (resolve) begin
            if (stat_branches != 32'hFFFF_FFFF) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random traffic against a
// queue-based reference model. Stat counters are checked when BRU_STATS_EN is defined.
module tb_branch_resolve_unit;

    localparam int HIST_W = 10;
    localparam int QDEPTH = 4;

    typedef struct packed {
        logic [31:0]       pc;
        logic [HIST_W-1:0] hist;
        logic              res;
        logic              ok;
        logic              which;
    } rec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_pc = '0;
    logic [31:0]       in_inst = '0;
    logic [31:0]       in_rs1_data = '0;
    logic [31:0]       in_rs2_data = '0;
    logic              in_pdt_res = 1'b0;
    logic              in_which_pdt = 1'b0;
    logic [HIST_W-1:0] in_history = '0;
    logic              flush;
    logic [31:0]       redirect_pc;
    logic              upd_valid;
    logic              upd_ready = 1'b0;
    logic [31:0]       upd_pc;
    logic [HIST_W-1:0] upd_history;
    logic              upd_branch_res;
    logic              upd_pdt_true;
    logic              upd_which_pdt;
`ifdef BRU_STATS_EN
    logic [31:0]       stat_branches;
    logic [31:0]       stat_mispredicts;
`endif

    branch_resolve_unit #(.HIST_W(HIST_W), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_pdt_res(in_pdt_res), .in_which_pdt(in_which_pdt), .in_history(in_history),
        .flush(flush), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_history(upd_history),
        .upd_branch_res(upd_branch_res), .upd_pdt_true(upd_pdt_true),
        .upd_which_pdt(upd_which_pdt)
`ifdef BRU_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    rec_t        mq[$];
    rec_t        m_last = '0;
    logic        m_flush = 1'b0;
    logic [31:0] m_redirect = '0;
    int          cur_imm = 0;
    int unsigned m_branches = 0;
    int unsigned m_mispred = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_br(input logic [2:0] f3, input int imm);
        logic [12:0] i;
        i = imm[12:0];
        return {i[12], i[10:5], 5'd2, 5'd1, f3, i[4:1], i[11], 7'b1100011};
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint ua, ub;
        sa = a; sb = b;
        ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive_br(input logic [2:0] f3, input int imm, input logic [31:0] pc,
                            input logic [31:0] a, input logic [31:0] b, input logic pdt);
        in_valid     = 1'b1;
        in_inst      = enc_br(f3, imm);
        cur_imm      = imm;
        in_pc        = pc;
        in_rs1_data  = a;
        in_rs2_data  = b;
        in_pdt_res   = pdt;
        in_which_pdt = $urandom_range(0, 1);
        in_history   = HIST_W'($urandom);
    endtask

    task automatic model_reset();
        mq.delete();
        m_last     = '0;
        m_flush    = 1'b0;
        m_redirect = '0;
        m_branches = 0;
        m_mispred  = 0;
    endtask

    // One clock: predict from current inputs, advance one edge, compare all outputs.
    task automatic step();
        logic        exp_rdy, acc, br, tk, mis, pop;
        logic [31:0] tgt;
        rec_t        exp_head;
        rec_t        got;
        exp_rdy = (mq.size() < QDEPTH);
        n_checks++;
        if (in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL in_ready: got %b required %b", in_ready, exp_rdy);
        end
        acc = in_valid && exp_rdy;
        br  = acc && (in_inst[6:0] == 7'b1100011) && !m_flush;
        tk  = ref_taken(in_inst[14:12], in_rs1_data, in_rs2_data);
        mis = (tk != in_pdt_res);
        tgt = in_pc + 32'(cur_imm);
        pop = upd_ready && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (pop) m_last = mq.pop_front();
        if (br) begin
            mq.push_back('{pc: in_pc, hist: in_history, res: tk, ok: !mis, which: in_which_pdt});
            if (m_branches != 32'hFFFF_FFFF) m_branches++;
            if (mis && m_mispred != 32'hFFFF_FFFF) m_mispred++;
        end
        m_flush = br && mis;
        if (m_flush) m_redirect = tk ? tgt : in_pc + 32'd4;
        n_checks++;
        if (flush !== m_flush) begin
            n_fail++;
            $display("FAIL flush: got %b required %b", flush, m_flush);
        end
        n_checks++;
        if (redirect_pc !== m_redirect) begin
            n_fail++;
            $display("FAIL redirect_pc: got %h required %h", redirect_pc, m_redirect);
        end
        n_checks++;
        if (upd_valid !== (mq.size() > 0)) begin
            n_fail++;
            $display("FAIL upd_valid: got %b required %b", upd_valid, mq.size() > 0);
        end
        exp_head = (mq.size() > 0) ? mq[0] : m_last;
        got = {upd_pc, upd_history, upd_branch_res, upd_pdt_true, upd_which_pdt};
        n_checks++;
        if (got !== exp_head) begin
            n_fail++;
            $display("FAIL upd_record: got pc=%h h=%h res=%b ok=%b w=%b required pc=%h h=%h res=%b ok=%b w=%b",
                     got.pc, got.hist, got.res, got.ok, got.which,
                     exp_head.pc, exp_head.hist, exp_head.res, exp_head.ok, exp_head.which);
        end
`ifdef BRU_STATS_EN
        n_checks++;
        if (stat_branches !== m_branches || stat_mispredicts !== m_mispred) begin
            n_fail++;
            $display("FAIL stats: got br=%0d mis=%0d required br=%0d mis=%0d",
                     stat_branches, stat_mispredicts, m_branches, m_mispred);
        end
`endif
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        upd_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        upd_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        upd_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (flush !== 1'b0 || redirect_pc !== 32'd0 || upd_valid !== 1'b0 || upd_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got flush=%b redir=%h upd_valid=%b upd_pc=%h required 0 0 0 0",
                     flush, redirect_pc, upd_valid, upd_pc);
        end
        step();
    endtask

    task automatic test_directed();
        drive_br(3'b000, 16, 32'h100, 32'd5, 32'd5, 1'b0);
        step();
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h110 || upd_pc !== 32'h100
            || upd_branch_res !== 1'b1 || upd_pdt_true !== 1'b0) begin
            n_fail++;
            $display("FAIL beq_taken: got flush=%b redir=%h pc=%h res=%b ok=%b required 1 110 100 1 0",
                     flush, redirect_pc, upd_pc, upd_branch_res, upd_pdt_true);
        end
        in_valid = 1'b0;
        step();
        drain();
        drive_br(3'b100, 64, 32'h200, 32'hFFFF_FFFF, 32'd1, 1'b1);
        step();
        n_checks++;
        if (flush !== 1'b0 || upd_pdt_true !== 1'b1 || upd_branch_res !== 1'b1) begin
            n_fail++;
            $display("FAIL blt_signed: got flush=%b ok=%b res=%b required 0 1 1",
                     flush, upd_pdt_true, upd_branch_res);
        end
        drive_br(3'b110, 64, 32'h300, 32'hFFFF_FFFF, 32'd1, 1'b1);
        step();
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h304) begin
            n_fail++;
            $display("FAIL bltu: got flush=%b redir=%h required 1 304", flush, redirect_pc);
        end
        in_valid = 1'b0;
        step();
        // fall-through wraps past the top of the address space
        drive_br(3'b000, -8, 32'hFFFF_FFFC, 32'd1, 32'd2, 1'b1);
        step();
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL pc_wrap: got flush=%b redir=%h required 1 00000000", flush, redirect_pc);
        end
        in_valid = 1'b0;
        step();
        drain();
    endtask

    task automatic test_backpressure();
        upd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_br(3'b001, 8, 32'h1000 + 32'(i * 4), 32'd1, 32'd2, 1'b1);
            step();
        end
        n_checks++;
        if (in_ready !== 1'b0 || upd_pc !== 32'h1000) begin
            n_fail++;
            $display("FAIL fifo_full: got in_ready=%b head=%h required 0 00001000", in_ready, upd_pc);
        end
        in_valid = 1'b0;
        upd_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (in_ready !== 1'b1 || upd_valid !== 1'b0 || upd_pc !== 32'h100C) begin
            n_fail++;
            $display("FAIL drained: got in_ready=%b upd_valid=%b last=%h required 1 0 0000100c",
                     in_ready, upd_valid, upd_pc);
        end
        upd_ready = 1'b0;
    endtask

    task automatic test_squash();
        drive_br(3'b000, 32, 32'h2000, 32'd3, 32'd3, 1'b0);
        step();
        drive_br(3'b000, 32, 32'h2004, 32'd3, 32'd3, 1'b0);
        step();
        n_checks++;
        if (flush !== 1'b0 || mq.size() != 1) begin
            n_fail++;
            $display("FAIL squash: got flush=%b required 0", flush);
        end
        // two mispredicts separated by an idle cycle each flush
        in_valid = 1'b0;
        step();
        drive_br(3'b001, 32, 32'h3000, 32'd3, 32'd3, 1'b1);
        step();
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h3004) begin
            n_fail++;
            $display("FAIL second_flush: got flush=%b redir=%h required 1 00003004", flush, redirect_pc);
        end
        in_valid = 1'b0;
        step();
        drain();
    endtask

    task automatic test_async_reset();
        upd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_br(3'b000, 12, 32'h4000 + 32'(i * 4), 32'd7, 32'd7, (i == 2) ? 1'b0 : 1'b1);
            step();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (upd_valid !== 1'b0 || flush !== 1'b0 || upd_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: got upd_valid=%b flush=%b upd_pc=%h required 0 0 0",
                     upd_valid, flush, upd_pc);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_br(3'b101, 20, 32'h5000 + 32'(i * 4), 32'd9, 32'd1, 1'b1);
            step();
        end
        n_checks++;
        if (in_ready !== 1'b0 || upd_pc !== 32'h5000) begin
            n_fail++;
            $display("FAIL refill_after_reset: got in_ready=%b head=%h required 0 00005000", in_ready, upd_pc);
        end
        drain();
    endtask

`ifdef BRU_STATS_EN
    task automatic test_stats();
        int unsigned b0, m0;
        b0 = stat_branches;
        m0 = stat_mispredicts;
        upd_ready = 1'b1;
        drive_br(3'b000, 8, 32'h6000, 32'd1, 32'd1, 1'b1);  step();
        drive_br(3'b001, 8, 32'h6004, 32'd1, 32'd1, 1'b0);  step();
        in_inst = 32'h0050_0093;  step();
        drive_br(3'b110, 8, 32'h600C, 32'd1, 32'd2, 1'b0);  step();
        in_valid = 1'b0;  step();
        n_checks++;
        if (stat_branches - b0 !== 32'd3 || stat_mispredicts - m0 !== 32'd1) begin
            n_fail++;
            $display("FAIL stats_delta: got br+%0d mis+%0d required br+3 mis+1",
                     stat_branches - b0, stat_mispredicts - m0);
        end
        drain();
    endtask
`endif

    task automatic test_random();
        logic [31:0] vals [6];
        vals[0] = 32'd0; vals[1] = 32'd1; vals[2] = 32'hFFFF_FFFF;
        vals[3] = 32'h8000_0000; vals[4] = 32'h7FFF_FFFF; vals[5] = 32'd42;
        for (int n = 0; n < 400; n++) begin
            drive_br(3'($urandom_range(0, 7)), int'($urandom_range(0, 4095)) * 2 - 4096,
                     {$urandom} & 32'hFFFF_FFFC,
                     vals[$urandom_range(0, 5)], vals[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) in_inst[6:0] = 7'b0010011;
            in_valid  = ($urandom_range(0, 3) != 0);
            upd_ready = ($urandom_range(0, 2) == 0);
            step();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_squash();
        test_async_reset();
`ifdef BRU_STATS_EN
        test_stats();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
